// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - I2S master transmitter: sclk/ws from mclk, one-deep holding register, MSB-first serialiser
// Define I2S_TX_LJ_EN for left-justified output (MSB on the ws edge instead of one sclk later).

module i2s_transmitter #(
  parameter int sclk_ws_ratio   = 64,
  parameter int mclk_sclk_ratio = 4,
  parameter int d_width         = 24
) (
  input  logic                      mclk,
  input  logic                      reset_n,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  input  logic signed [d_width-1:0] l_data_tx,
  input  logic signed [d_width-1:0] r_data_tx,
  output logic                      sclk,
  output logic                      ws,
  output logic                      sd_tx,
  output logic                      underrun
);

  localparam int MC_HALF = mclk_sclk_ratio / 2;
  localparam int MC_W    = (MC_HALF > 1) ? $clog2(MC_HALF) : 1;
  localparam int WS_W    = (sclk_ws_ratio > 1) ? $clog2(sclk_ws_ratio) : 1;
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(MC_HALF - 1);
  localparam logic [WS_W-1:0] WS_LAST = WS_W'(sclk_ws_ratio - 1);

`ifdef I2S_TX_LJ_EN
  localparam bit LJ_MODE      = 1'b1;
  localparam int LAST_BIT_CNT = 2 * d_width - 3;
`else
  localparam bit LJ_MODE      = 1'b0;
  localparam int LAST_BIT_CNT = 2 * d_width - 1;
`endif

  logic [MC_W-1:0]    mclk_cnt_q, mclk_cnt_d;
  logic [WS_W-1:0]    ws_cnt_q, ws_cnt_d;
  logic               sclk_q, sclk_d;
  logic               ws_q, ws_d;
  logic               sd_q, sd_d;
  logic               underrun_q, underrun_d;
  logic               hold_full_q, hold_full_d;
  logic [d_width-1:0] hold_l_q, hold_l_d;
  logic [d_width-1:0] hold_r_q, hold_r_d;
  logic [d_width-1:0] frame_l_q, frame_l_d;
  logic [d_width-1:0] frame_r_q, frame_r_d;
  logic [d_width-1:0] shift_q, shift_d;

  logic               toggle;
  logic               fall;
  logic               ws_wrap;
  logic               transfer;
  logic [d_width-1:0] load_val;

  always_comb begin
    toggle   = (mclk_cnt_q == MC_LAST);
    fall     = toggle && sclk_q;
    ws_wrap  = toggle && (ws_cnt_q == WS_LAST);
    transfer = ws_wrap && ws_q;

    mclk_cnt_d  = toggle ? '0 : mclk_cnt_q + 1'b1;
    ws_cnt_d    = ws_cnt_q;
    sclk_d      = sclk_q;
    ws_d        = ws_q;
    sd_d        = sd_q;
    underrun_d  = 1'b0;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    frame_l_d   = frame_l_q;
    frame_r_d   = frame_r_q;
    shift_d     = shift_q;
    load_val    = '0;

    if (toggle) begin
      sclk_d   = ~sclk_q;
      ws_cnt_d = ws_wrap ? '0 : ws_cnt_q + 1'b1;
    end
    if (ws_wrap) begin
      ws_d = ~ws_q;
    end

    // A starved frame keeps the previous pair in the frame registers, so it repeats
    if (transfer) begin
      if (hold_full_q) begin
        frame_l_d   = hold_l_q;
        frame_r_d   = hold_r_q;
        hold_full_d = 1'b0;
      end else if (tx_valid) begin
        frame_l_d = l_data_tx;
        frame_r_d = r_data_tx;
      end else begin
        underrun_d = 1'b1;
      end
    end else if (tx_valid && !hold_full_q) begin
      hold_l_d    = l_data_tx;
      hold_r_d    = r_data_tx;
      hold_full_d = 1'b1;
    end

    // ws wrap is always a falling sclk edge; the left load takes this cycle's transfer result
    if (fall) begin
      sd_d = 1'b0;
      if (ws_wrap) begin
        load_val = ws_q ? frame_l_d : frame_r_q;
        if (LJ_MODE) begin
          sd_d    = load_val[d_width-1];
          shift_d = {load_val[d_width-2:0], 1'b0};
        end else begin
          shift_d = load_val;
        end
      end else if (int'(ws_cnt_q) <= LAST_BIT_CNT) begin
        sd_d    = shift_q[d_width-1];
        shift_d = {shift_q[d_width-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      mclk_cnt_q  <= '0;
      ws_cnt_q    <= '0;
      sclk_q      <= 1'b0;
      ws_q        <= 1'b0;
      sd_q        <= 1'b0;
      underrun_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      frame_l_q   <= '0;
      frame_r_q   <= '0;
      shift_q     <= '0;
    end else begin
      mclk_cnt_q  <= mclk_cnt_d;
      ws_cnt_q    <= ws_cnt_d;
      sclk_q      <= sclk_d;
      ws_q        <= ws_d;
      sd_q        <= sd_d;
      underrun_q  <= underrun_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      frame_l_q   <= frame_l_d;
      frame_r_q   <= frame_r_d;
      shift_q     <= shift_d;
    end
  end

  assign tx_ready = ~hold_full_q;
  assign sclk     = sclk_q;
  assign ws       = ws_q;
  assign sd_tx    = sd_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb/tb_i2s_transmitter.sv - randomized bench for i2s_transmitter against a frame-level reference model
// Define I2S_TX_LJ_EN here as well as in the RTL build for the left-justified variant.

module tb_i2s_transmitter;

  localparam int D     = 24;
  localparam int SWR   = 64;
  localparam int MSR   = 4;
  localparam int HALF  = MSR / 2;
  localparam int CHAN  = HALF * SWR;
  localparam int FRAME = 2 * CHAN;
`ifdef I2S_TX_LJ_EN
  localparam int FIRST = 0;
`else
  localparam int FIRST = 1;
`endif

  logic                mclk = 1'b0;
  logic                reset_n = 1'b0;
  logic                tx_valid = 1'b0;
  logic signed [D-1:0] l_data_tx = '0;
  logic signed [D-1:0] r_data_tx = '0;
  logic                tx_ready, sclk, ws, sd_tx, underrun;

  int vec = 0;
  int errs = 0;

  i2s_transmitter #(.sclk_ws_ratio(SWR), .mclk_sclk_ratio(MSR), .d_width(D)) dut (
    .mclk(mclk), .reset_n(reset_n), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .l_data_tx(l_data_tx), .r_data_tx(r_data_tx), .sclk(sclk), .ws(ws),
    .sd_tx(sd_tx), .underrun(underrun)
  );

  always #5 mclk = ~mclk;

  // Reference model: e counts mclk edges since reset release; a frame boundary every FRAME edges
  int         e;
  int         m_und = 0;
  logic       m_full;
  logic [D-1:0] m_hl, m_hr, m_fl, m_fr;
  logic [D:0] exp_q[$];

  always @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      e = 0; m_full = 1'b0; m_hl = '0; m_hr = '0; m_fl = '0; m_fr = '0;
      exp_q.delete();
      exp_q.push_back({1'b1, {D{1'b0}}});
    end else begin
      if ((e + 1) % FRAME == 0) begin
        if (m_full) begin
          m_fl = m_hl; m_fr = m_hr; m_full = 1'b0;
        end else if (tx_valid) begin
          m_fl = l_data_tx; m_fr = r_data_tx;
        end else begin
          m_und++;
        end
        exp_q.push_back({1'b0, m_fl});
        exp_q.push_back({1'b1, m_fr});
      end else if (tx_valid && !m_full) begin
        m_hl = l_data_tx; m_hr = r_data_tx; m_full = 1'b1;
      end
      e = e + 1;
    end
  end

  // Receiver: samples sd_tx on sclk rising edges like the DAC, one word per ws half-period
  logic [D+1:0] rx_q[$];
  int           o_und = 0;
  int           idx;
  logic         p_sclk, p_ws, coll, cur_ch, bad;
  logic [D-1:0] word;

  always @(negedge mclk) begin
    if (!reset_n) begin
      coll = 1'b0; p_sclk = 1'b0; p_ws = 1'b0;
      rx_q.delete();
    end else begin
      if (underrun === 1'b1) o_und++;
      if (!p_sclk && sclk) begin
        if (ws !== p_ws) begin
          if (coll) rx_q.push_back({bad, cur_ch, word});
          coll = 1'b1; cur_ch = ws; idx = 0; word = '0; bad = 1'b0;
        end
        if (coll) begin
          if (idx >= FIRST && idx < FIRST + D) word = {word[D-2:0], sd_tx};
          else if (sd_tx !== 1'b0) bad = 1'b1;
          idx++;
        end
        p_ws = ws;
      end
      p_sclk = sclk;
    end
  end

  task automatic wait_phase(input int p);
    for (int i = 0; i <= FRAME + 1; i++) begin
      @(negedge mclk);
      if (e % FRAME == p) return;
    end
    vec++; errs++;
    $display("FAIL wait_phase: timed out at e=%0d, wanted phase %0d", e, p);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge mclk);
    vec += 5;
    if (sclk !== 1'b0)     begin errs++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    if (ws !== 1'b0)       begin errs++; $display("FAIL reset_ws: got %b want 0", ws); end
    if (sd_tx !== 1'b0)    begin errs++; $display("FAIL reset_sd: got %b want 0", sd_tx); end
    if (underrun !== 1'b0) begin errs++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    if (tx_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    reset_n = 1'b1;
  endtask

  task automatic test_idle();
    logic [D+1:0] got; logic [D:0] want; int n = 0; int u0 = o_und;
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      @(negedge mclk);
      vec += 4;
      if (sclk !== (((e / HALF) % 2) != 0)) begin errs++; $display("FAIL idle_sclk: e=%0d got %b", e, sclk); end
      if (ws !== (((e / CHAN) % 2) != 0))   begin errs++; $display("FAIL idle_ws: e=%0d got %b", e, ws); end
      if (sd_tx !== 1'b0)    begin errs++; $display("FAIL idle_sd: e=%0d got %b want 0", e, sd_tx); end
      if (tx_ready !== 1'b1) begin errs++; $display("FAIL idle_ready: e=%0d got %b want 1", e, tx_ready); end
    end
    vec++;
    if (o_und - u0 != 2) begin errs++; $display("FAIL idle_underrun: got %0d pulses want 2", o_und - u0); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); n++; vec++;
      if (got !== {1'b0, want}) begin errs++; $display("FAIL idle_word: got %h want %h", got, want); end
    end
    vec++;
    if (n < 3) begin errs++; $display("FAIL idle_word_count: got %0d want >=3", n); end
  endtask

  task automatic test_pattern(input logic [D-1:0] l, input logic [D-1:0] r);
    logic [D+1:0] got; logic [D:0] want; int n = 0; int u0;
    wait_phase(10);
    tx_valid = 1'b1; l_data_tx = l; r_data_tx = r;
    @(negedge mclk);
    tx_valid = 1'b0;
    vec++;
    if (tx_ready !== 1'b0) begin errs++; $display("FAIL pattern_ready: got %b want 0", tx_ready); end
    u0 = o_und;
    wait_phase(2);
    vec++;
    if (o_und != u0) begin errs++; $display("FAIL pattern_underrun: got %0d pulses want 0", o_und - u0); end
    repeat (FRAME + 8) @(negedge mclk);
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); n++; vec++;
      if (got !== {1'b0, want}) begin errs++; $display("FAIL pattern_word: got %h want %h", got, want); end
    end
    vec++;
    if (n < 2) begin errs++; $display("FAIL pattern_word_count: got %0d want >=2", n); end
  endtask

  task automatic test_handshake();
    logic [D+1:0] got; logic [D:0] want; int n = 0; bit done = 0;
    wait_phase(20);
    tx_valid = 1'b1; l_data_tx = D'($urandom); r_data_tx = D'($urandom);
    @(negedge mclk);
    l_data_tx = D'($urandom); r_data_tx = D'($urandom);
    for (int i = 0; i < FRAME + 4 && !done; i++) begin
      vec++;
      if (e % FRAME == 0) begin
        if (tx_ready !== 1'b1) begin errs++; $display("FAIL hs_ready_after_transfer: got %b want 1", tx_ready); end
        @(negedge mclk);
        vec++;
        if (tx_ready !== 1'b0) begin errs++; $display("FAIL hs_second_accept: got %b want 0", tx_ready); end
        done = 1;
      end else if (tx_ready !== 1'b0) begin
        errs++; $display("FAIL hs_ready_held: e=%0d got %b want 0", e, tx_ready);
      end
      if (!done) @(negedge mclk);
    end
    tx_valid = 1'b0;
    vec++;
    if (!done) begin errs++; $display("FAIL hs_transfer_seen: got none want 1"); end
    repeat (FRAME + 8) @(negedge mclk);
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); n++; vec++;
      if (got !== {1'b0, want}) begin errs++; $display("FAIL hs_word: got %h want %h", got, want); end
    end
    vec++;
    if (n < 2) begin errs++; $display("FAIL hs_word_count: got %0d want >=2", n); end
  endtask

  task automatic test_bypass();
    logic [D+1:0] got; logic [D:0] want; int n = 0; int u0;
    wait_phase(FRAME - 1);
    wait_phase(FRAME - 1);
    u0 = o_und;
    tx_valid = 1'b1; l_data_tx = 24'h123456; r_data_tx = D'($urandom);
    @(negedge mclk);
    tx_valid = 1'b0;
    vec += 3;
    if (tx_ready !== 1'b1) begin errs++; $display("FAIL bypass_ready: got %b want 1", tx_ready); end
    if (underrun !== 1'b0) begin errs++; $display("FAIL bypass_underrun: got %b want 0", underrun); end
    repeat (FRAME + 8) @(negedge mclk);
    if (o_und - u0 != 1) begin errs++; $display("FAIL bypass_underrun_count: got %0d want 1", o_und - u0); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); n++; vec++;
      if (got !== {1'b0, want}) begin errs++; $display("FAIL bypass_word: got %h want %h", got, want); end
    end
    vec++;
    if (n < 2) begin errs++; $display("FAIL bypass_word_count: got %0d want >=2", n); end
  endtask

  task automatic test_starve();
    logic [D+1:0] got; logic [D:0] want; int n = 0; int u0;
    wait_phase(30);
    tx_valid = 1'b1; l_data_tx = 24'h00000F; r_data_tx = 24'hFFFFF0;
    @(negedge mclk);
    tx_valid = 1'b0;
    wait_phase(0);
    u0 = o_und;
    repeat (3 * FRAME + 8) @(negedge mclk);
    vec++;
    if (o_und - u0 != 3) begin errs++; $display("FAIL starve_underrun: got %0d pulses want 3", o_und - u0); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); n++; vec++;
      if (got !== {1'b0, want}) begin errs++; $display("FAIL starve_word: got %h want %h", got, want); end
    end
    vec++;
    if (n < 6) begin errs++; $display("FAIL starve_word_count: got %0d want >=6", n); end
  endtask

  task automatic test_random();
    logic [D+1:0] got; logic [D:0] want; int n = 0; int u0 = o_und; int mu0 = m_und;
    for (int i = 0; i < 6 * FRAME; i++) begin
      @(negedge mclk);
      vec++;
      if (tx_ready !== !m_full) begin errs++; $display("FAIL rand_ready: e=%0d got %b want %b", e, tx_ready, !m_full); end
      if ($urandom_range(0, 149) == 0) begin
        tx_valid = 1'b1; l_data_tx = D'($urandom); r_data_tx = D'($urandom);
      end else begin
        tx_valid = 1'b0;
      end
    end
    tx_valid = 1'b0;
    repeat (FRAME + 8) @(negedge mclk);
    vec++;
    if (o_und - u0 != m_und - mu0) begin
      errs++; $display("FAIL rand_underrun: got %0d pulses want %0d", o_und - u0, m_und - mu0);
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); n++; vec++;
      if (got !== {1'b0, want}) begin errs++; $display("FAIL rand_word: got %h want %h", got, want); end
    end
    vec++;
    if (n < 12) begin errs++; $display("FAIL rand_word_count: got %0d want >=12", n); end
  endtask

  task automatic test_reset_mid();
    logic [D+1:0] got; logic [D:0] want; int n = 0;
    tx_valid = 1'b1; l_data_tx = 24'h7F0F0F; r_data_tx = 24'h80F0F0;
    @(negedge mclk);
    tx_valid = 1'b0;
    wait_phase(CHAN + 40);
    #3 reset_n = 1'b0;
    #1;
    vec += 5;
    if (sclk !== 1'b0)     begin errs++; $display("FAIL rmid_sclk: got %b want 0", sclk); end
    if (ws !== 1'b0)       begin errs++; $display("FAIL rmid_ws: got %b want 0", ws); end
    if (sd_tx !== 1'b0)    begin errs++; $display("FAIL rmid_sd: got %b want 0", sd_tx); end
    if (tx_ready !== 1'b1) begin errs++; $display("FAIL rmid_ready: got %b want 1", tx_ready); end
    if (underrun !== 1'b0) begin errs++; $display("FAIL rmid_underrun: got %b want 0", underrun); end
    repeat (2) @(negedge mclk);
    reset_n = 1'b1;
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      @(negedge mclk);
      vec += 2;
      if (sclk !== (((e / HALF) % 2) != 0)) begin errs++; $display("FAIL rmid_restart_sclk: e=%0d got %b", e, sclk); end
      if (ws !== (((e / CHAN) % 2) != 0))   begin errs++; $display("FAIL rmid_restart_ws: e=%0d got %b", e, ws); end
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); n++; vec++;
      if (got !== {1'b0, want}) begin errs++; $display("FAIL rmid_word: got %h want %h", got, want); end
    end
    vec++;
    if (n < 3) begin errs++; $display("FAIL rmid_word_count: got %0d want >=3", n); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_pattern(24'h800001, 24'h7FFFFE);
    test_pattern(24'hA5A5A5, 24'h5A5A5A);
    test_handshake();
    test_bypass();
    test_starve();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- I2S master transmitter for the audio effects path. Drives the CS4344 DAC from the processed sample stream.
- Generates its own sclk and ws from mclk, using the same ratios as the capture side. The default 64/4 ratios give 44.1 kHz ws, 2.82 MHz sclk and 11.29 MHz mclk.
- Accepts left/right sample pairs over a valid/ready handshake into a one-deep holding register.
- Serialises each channel MSB-first, in standard I2S format.

Parameters:
- sclk_ws_ratio, 64: sclk half-periods per ws half-period. Must be even. Gives sclk_ws_ratio/2 sclk periods per channel.
- mclk_sclk_ratio, 4: mclk periods per sclk period. Must be even and ≥2.
- d_width, 24: sample width. Must be ≤ sclk_ws_ratio/2 - 1.

Ports:
- mclk  in  1  master clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- tx_valid  in  1  sample pair valid.
- tx_ready  out  1  holding register empty; the pair is accepted when tx_valid && tx_ready on a mclk rising edge.
- l_data_tx  in  d_width  signed left sample.
- r_data_tx  in  d_width  signed right sample.
- sclk  out  1  serial bit clock.
- ws  out  1  word select; 0 = left, 1 = right.
- sd_tx  out  1  serial data to DAC.
- underrun  out  1  one-mclk pulse when a frame starts with no new pair.

Behaviour:
- Interface: one clock, mclk. Reset is asynchronous, active-low (reset_n). All state is clocked on the mclk rising edge.
- Reset values:
  - sclk=0, ws=0, sd_tx=0, underrun=0, tx_ready=1.
  - mclk/sclk counter=0, sclk/ws counter=0.
  - Holding register empty and 0; frame registers (left, right) 0; shift register 0.
- Reset asserted mid-frame aborts the frame immediately. Output resumes cleanly from the reset state.
- sclk generation:
  - mclk counter counts 0..mclk_sclk_ratio/2-1.
  - On the terminal count it wraps to 0 and sclk toggles (a toggle event).
  - Defaults: sclk toggles every 2 mclk.
- ws generation:
  - ws counter counts toggle events 0..sclk_ws_ratio-1.
  - On the toggle event with counter == sclk_ws_ratio-1, the counter wraps to 0 and ws toggles.
  - Because sclk starts at 0 and the ratio is even, ws always changes on a falling sclk edge.
  - Defaults: 128 mclk per channel, 256 mclk per frame.
- Data timing:
  - sd_tx changes only on falling sclk edges (toggle events where sclk goes 1→0).
  - On a ws toggle the shift register is loaded:
    - ws 1→0: loads the left frame register.
    - ws 0→1: loads the right frame register.
  - MSB is driven on the next falling edge (ws counter == 1), one sclk after the ws change.
  - Remaining bits follow on falling edges at ws counter 3, 5, …, 2*d_width-1.
  - After d_width bits, sd_tx is held at 0 until the next ws toggle.
- Frame transfer (ws 1→0 edge):
  - Holding full: the pair moves into the frame registers, holding becomes empty, tx_ready=1 next cycle.
  - Holding empty, tx_valid=0: frame registers keep the previous pair (last pair repeats); underrun pulses for 1 mclk.
  - Holding empty, tx_valid=1 same cycle: the incoming pair bypasses straight into the frame registers. Holding stays empty, tx_ready stays 1, no underrun.
  - Holding full, tx_valid=1 same cycle: tx_ready=0, so the input is ignored; the old holding pair transfers.
- Accept: when tx_valid && tx_ready outside the transfer cycle, the pair is captured into holding and tx_ready=0 from the next cycle.
- Start-up: the first left half-period after reset transmits zeros. The right half-period also transmits zeros. The first real data appears after the first ws 1→0 transfer.
- Data is sent as two's complement unchanged; there is no width conversion.

Optional Feature:
- Macro: I2S_TX_LJ_EN.
- Defined (left-justified format): the shift register loads one falling edge earlier, at the ws counter wrap.
  - MSB is driven on the same falling edge as the ws change.
  - Remaining bits follow on falling edges at counter 1, 3, …, 2*d_width-3; zeros after that.
  - The d_width ≤ sclk_ws_ratio/2 constraint is relaxed accordingly.
- Undefined: standard I2S with the one-sclk MSB delay, as specified above.

Test Plan:
- Reset release, no tx_valid → sclk period 4 mclk; ws period 256 mclk; sd_tx=0 throughout; underrun pulses once per frame at each ws 1→0.
- Pair L=0x800001, R=0x7FFFFE loaded before a ws 1→0 edge → sampling sd_tx on sclk rising edges gives 24 left bits 0x800001 starting at the 2nd rising edge after ws fall; 24 right bits 0x7FFFFE after ws rise; trailing zeros; underrun=0.
- Handshake: present a pair → tx_ready drops the next cycle; a second pair held valid is not accepted until the transfer; tx_ready returns 1 one cycle after the ws 1→0 edge.
- tx_valid=1 with holding empty exactly on the transfer cycle, L=0x123456 → that pair is sent in this frame; tx_ready stays 1; no underrun.
- Starve after L=0x00000F, R=0xFFFFF0 → the same pair repeats every frame; underrun pulses once per frame.
- Assert reset_n=0 mid-right-channel → sclk, ws, sd_tx go to 0 asynchronously and tx_ready=1; after release, timing restarts from counter 0.
- With I2S_TX_LJ_EN, L=0xA5A5A5 → MSB is on sd_tx at the first rising edge after ws fall.
